wb_stage_skid_reg: RTL and testbench
====================================

// Module: wb_stage_skid_reg
// PURPOSE
//   Parametrised pipeline stage register with a valid/ready handshake.
//   It replaces fixed stall-vector stage registers such as the MEM->WB register.
//   - Optional 2-entry skid buffer, so up_ready_o is a registered signal.
//   - Synchronous flush.
//   - Zeroed bubble payload.
//   - Saturating back-pressure counter.
//   It sits between any two pipeline stages. For MEM->WB it carries the wb_pkg::wb_payload_t struct.
// PARAMETERS
//   DATA_W       72  payload width in bits (default = wb_payload_t: waddr5, we1, whilo2, hi32, lo32)
//   SKID_EN      1   1: two entries, up_ready_o is driven from a flop; 0: one entry, up_ready_o is combinational
//   STALL_CNT_W  16  width of the back-pressure cycle counter
// PORTS
//   clk             in   1            clock, rising edge
//   rst             in   1            synchronous reset, active-high
//   flush_i         in   1            discard all held entries (exception or branch redirect)
//   up_valid_i      in   1            upstream has a payload
//   up_ready_o      out  1            stage can accept a payload this cycle
//   up_data_i       in   DATA_W       upstream payload
//   dn_valid_o      out  1            downstream payload is valid
//   dn_ready_i      in   1            downstream consumes the payload this cycle
//   dn_data_o       out  DATA_W       downstream payload; all zeros whenever dn_valid_o=0
//   occupancy_o     out  2            number of entries held (0..2; max 1 when SKID_EN=0)
//   stall_cycles_o  out  STALL_CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0, saturating
// BEHAVIOUR
//   Reset: all outputs are 0 except up_ready_o=1 (1 in both modes). Both entries are invalid and zeroed. The counter is 0.
//   Handshake: a transfer occurs when valid and ready are both high on a rising edge.
//     - dn_valid_o is not allowed to drop without a transfer or a flush.
//     - dn_data_o is stable while dn_valid_o=1 and dn_ready_i=0.
//   Latency: a payload accepted in cycle N appears on dn_* in cycle N+1. Strict FIFO order is kept.
//   SKID_EN=1 state machine, based on the main/skid valid bits:
//     EMPTY: accept -> ONE.
//     ONE: the following transitions apply.
//       - accept and consume -> ONE; main takes the new data.
//       - accept only -> TWO; the new data goes to skid.
//       - consume only -> EMPTY.
//     TWO: up_ready_o=0.
//       - consume -> ONE; skid moves to main, and skid is zeroed.
//   up_ready_o = !skid_valid. It is registered and has no combinational path from dn_ready_i.
//   SKID_EN=0: up_ready_o = !dn_valid_o || dn_ready_i. A simultaneous consume and accept is a full-throughput replace.
//   Bubble zeroing: every entry that becomes invalid has its data cleared to 0. Invalid WB entries therefore always carry we=0 and whilo=0.
//   Flush: on the next edge both entries are invalid and zeroed, and dn_valid_o=0.
//     - Flush takes priority over a simultaneous accept; the accepted upstream beat is dropped.
//     - A simultaneous downstream transfer still completes in that cycle.
//   Counter: +1 on each cycle with dn_valid_o and !dn_ready_i. It holds at all ones (no wrap). It is cleared only by rst, not by flush.
//   Reset mid-transfer: rst overrides flush and all handshakes. No payload survives.
// STRUCTURE
//   wb_pkg: wb_payload_t struct, WB_PAYLOAD_W=72 constant, HILO write-enable encodings (2'b01 LO, 2'b10 HI, 2'b11 both).
//   Sub-module: sat_counter #(W) (increment enable, synchronous clear, saturate); reused by perf counters.
//   SKID_EN is selected with a generate block. No other hierarchy.
// TESTING
//   1. Reset with up_valid_i=1: outputs are 0, up_ready_o=1, and no acceptance occurs in the reset cycle.
//   2. Stream 8 payloads 0x01..0x08 with dn_ready_i=1:
//      - One per cycle, in order, latency 1, occupancy stays at 1.
//      - Verify in both SKID_EN values.
//   3. Back-pressure with SKID_EN=1:
//      - Hold dn_ready_i=0 and send A and B: occupancy reaches 2, up_ready_o=0, C is held upstream, and dn_data_o stays A.
//      - Release dn_ready_i: A, B, C are delivered in order, and stall_cycles_o equals the number of held cycles.
//   4. Flush while occupancy=2 with up_valid_i=1 (payload D):
//      - Next cycle dn_valid_o=0 and dn_data_o=0. D is not delivered. The counter is unchanged.
//   5. Force stall_cycles_o to all ones (STALL_CNT_W=4, 20 stalled cycles): the value holds at 4'hF.
//   6. Random valid/ready/flush for 10k cycles: the scoreboard confirms no loss, no duplication, order kept, and data=0 whenever valid=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: the MEM->WB payload and its HI/LO write-enable codes.
// Also holds the state encoding of the skid-buffered stage register.
package wb_pkg;

  typedef enum logic [1:0] {
    HILO_NONE = 2'b00,
    HILO_LO   = 2'b01,
    HILO_HI   = 2'b10,
    HILO_BOTH = 2'b11
  } hilo_we_e;

  typedef struct packed {
    logic [4:0]  waddr;
    logic        we;
    hilo_we_e    whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_payload_t;

  localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

  // Encoded so that the state value equals the number of held entries.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, zeroed bubbles and a saturating back-pressure counter.
module wb_stage_skid_reg
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_PAYLOAD_W,
  parameter bit SKID_EN     = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   up_valid_i,
  output logic                   up_ready_o,
  input  logic [DATA_W-1:0]      up_data_i,
  output logic                   dn_valid_o,
  input  logic                   dn_ready_i,
  output logic [DATA_W-1:0]      dn_data_o,
  output logic [1:0]             occupancy_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // Once dn_valid_o is raised it stays high with stable dn_data_o until consumed or flushed.
  logic up_accept;
  logic dn_consume;

  assign up_accept  = up_valid_i && up_ready_o;
  assign dn_consume = dn_valid_o && dn_ready_i;

  generate
    if (SKID_EN) begin : g_skid
      skid_state_e       state_q;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic              up_ready_q;

      // main_q always holds the oldest entry; skid_q only fills while main is stalled.
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          state_q    <= SKID_EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          up_ready_q <= 1'b1;
        end else begin
          case (state_q)
            SKID_EMPTY: begin
              if (up_accept) begin
                state_q <= SKID_ONE;
                main_q  <= up_data_i;
              end
            end
            SKID_ONE: begin
              if (up_accept && dn_consume) begin
                main_q <= up_data_i;
              end else if (up_accept) begin
                state_q    <= SKID_TWO;
                skid_q     <= up_data_i;
                up_ready_q <= 1'b0;
              end else if (dn_consume) begin
                state_q <= SKID_EMPTY;
                main_q  <= '0;
              end
            end
            SKID_TWO: begin
              if (dn_consume) begin
                state_q    <= SKID_ONE;
                main_q     <= skid_q;
                skid_q     <= '0;
                up_ready_q <= 1'b1;
              end
            end
            default: begin
              state_q    <= SKID_EMPTY;
              main_q     <= '0;
              skid_q     <= '0;
              up_ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign up_ready_o  = up_ready_q;
      assign dn_valid_o  = (state_q != SKID_EMPTY);
      assign dn_data_o   = main_q;
      assign occupancy_o = 2'(state_q);
    end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      // Consume and accept in the same cycle simply replaces the entry.
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (up_accept) begin
          valid_q <= 1'b1;
          data_q  <= up_data_i;
        end else if (dn_consume) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      end

      assign up_ready_o  = !valid_q || dn_ready_i;
      assign dn_valid_o  = valid_q;
      assign dn_data_o   = data_q;
      assign occupancy_o = {1'b0, valid_q};
    end
  endgenerate

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (dn_valid_o && !dn_ready_i),
    .cnt_o (stall_cycles_o)
  );

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Bench for wb_stage_skid_reg: skid (16- and 4-bit counter) and single-entry variants,
// with a FIFO scoreboard fed on acceptance and drained on downstream transfer.
module tb_wb_stage_skid_reg;

  localparam int W = 72;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // side a drives both the skid instances (16-bit and 4-bit counters)
  logic         flush_a, up_valid_a, dn_ready_a;
  logic [W-1:0] up_data_a;
  logic         up_ready_a, dn_valid_a;
  logic [W-1:0] dn_data_a;
  logic [1:0]   occ_a;
  logic [15:0]  stall_a;

  logic         up_ready_c, dn_valid_c;
  logic [W-1:0] dn_data_c;
  logic [1:0]   occ_c;
  logic [3:0]   stall_c;

  logic         flush_b, up_valid_b, dn_ready_b;
  logic [W-1:0] up_data_b;
  logic         up_ready_b, dn_valid_b;
  logic [W-1:0] dn_data_b;
  logic [1:0]   occ_b;
  logic [15:0]  stall_b;

  wb_stage_skid_reg #(.DATA_W(W), .SKID_EN(1'b1), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush_a),
    .up_valid_i(up_valid_a), .up_ready_o(up_ready_a), .up_data_i(up_data_a),
    .dn_valid_o(dn_valid_a), .dn_ready_i(dn_ready_a), .dn_data_o(dn_data_a),
    .occupancy_o(occ_a), .stall_cycles_o(stall_a)
  );

  wb_stage_skid_reg #(.DATA_W(W), .SKID_EN(1'b1), .STALL_CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush_i(flush_a),
    .up_valid_i(up_valid_a), .up_ready_o(up_ready_c), .up_data_i(up_data_a),
    .dn_valid_o(dn_valid_c), .dn_ready_i(dn_ready_a), .dn_data_o(dn_data_c),
    .occupancy_o(occ_c), .stall_cycles_o(stall_c)
  );

  wb_stage_skid_reg #(.DATA_W(W), .SKID_EN(1'b0), .STALL_CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush_b),
    .up_valid_i(up_valid_b), .up_ready_o(up_ready_b), .up_data_i(up_data_b),
    .dn_valid_o(dn_valid_b), .dn_ready_i(dn_ready_b), .dn_data_o(dn_data_b),
    .occupancy_o(occ_b), .stall_cycles_o(stall_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [15:0]  exp_stall_a, exp_stall_b;
  logic [3:0]   exp_stall_c;

  // Scoreboard: checks the state left by the last edge, then applies the coming edge's handshakes.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q_a.delete();
      exp_q_b.delete();
      exp_stall_a = '0;
      exp_stall_b = '0;
      exp_stall_c = '0;
    end else begin
      int na, nb;
      logic [W-1:0] ea, eb;
      na = exp_q_a.size();
      nb = exp_q_b.size();
      ea = (na != 0) ? exp_q_a[0] : '0;
      eb = (nb != 0) ? exp_q_b[0] : '0;

      tests_run++;
      if (dn_valid_a !== (na != 0) || occ_a !== 2'(na) || up_ready_a !== (na < 2) || dn_data_a !== ea) begin
        tests_failed++;
        $display("FAIL sb_skid: valid=%0b occ=%0d ready=%0b data=%h, want valid=%0b occ=%0d ready=%0b data=%h",
                 dn_valid_a, occ_a, up_ready_a, dn_data_a, na != 0, na, na < 2, ea);
      end
      tests_run++;
      if (stall_a !== exp_stall_a) begin
        tests_failed++;
        $display("FAIL sb_stall16: got %0d want %0d", stall_a, exp_stall_a);
      end
      tests_run++;
      if (dn_valid_c !== (na != 0) || occ_c !== 2'(na) || up_ready_c !== (na < 2) || dn_data_c !== ea || stall_c !== exp_stall_c) begin
        tests_failed++;
        $display("FAIL sb_stall4: valid=%0b occ=%0d ready=%0b data=%h stall=%h, want valid=%0b occ=%0d ready=%0b data=%h stall=%h",
                 dn_valid_c, occ_c, up_ready_c, dn_data_c, stall_c, na != 0, na, na < 2, ea, exp_stall_c);
      end
      tests_run++;
      if (dn_valid_b !== (nb != 0) || occ_b !== 2'(nb) || up_ready_b !== (nb == 0 || dn_ready_b) || dn_data_b !== eb) begin
        tests_failed++;
        $display("FAIL sb_single: valid=%0b occ=%0d ready=%0b data=%h, want valid=%0b occ=%0d ready=%0b data=%h",
                 dn_valid_b, occ_b, up_ready_b, dn_data_b, nb != 0, nb, nb == 0 || dn_ready_b, eb);
      end
      tests_run++;
      if (stall_b !== exp_stall_b) begin
        tests_failed++;
        $display("FAIL sb_single_stall: got %0d want %0d", stall_b, exp_stall_b);
      end

      if (na != 0 && !dn_ready_a && exp_stall_a != 16'hFFFF) exp_stall_a++;
      if (na != 0 && !dn_ready_a && exp_stall_c != 4'hF) exp_stall_c++;
      if (nb != 0 && !dn_ready_b && exp_stall_b != 16'hFFFF) exp_stall_b++;

      if (na != 0 && dn_ready_a) void'(exp_q_a.pop_front());
      if (flush_a) exp_q_a.delete();
      else if (up_valid_a && na < 2) exp_q_a.push_back(up_data_a);

      if (nb != 0 && dn_ready_b) void'(exp_q_b.pop_front());
      if (flush_b) exp_q_b.delete();
      else if (up_valid_b && (nb == 0 || dn_ready_b)) exp_q_b.push_back(up_data_b);
    end
  end

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    up_valid_a = v; up_data_a = d; dn_ready_a = r; flush_a = f;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    up_valid_b = v; up_data_b = d; dn_ready_b = r; flush_b = f;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; drive_a(1'b0, '0, 1'b1, 1'b0); drive_b(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b1, W'(72'hAA), 1'b1, 1'b0);
    drive_b(1'b1, W'(72'hBB), 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_a(1'b0, '0, 1'b1, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0);
    #2;
    tests_run++;
    if (dn_valid_a !== 1'b0 || dn_data_a !== '0 || occ_a !== 2'd0 || up_ready_a !== 1'b1 || stall_a !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_skid: valid=%0b data=%h occ=%0d ready=%0b stall=%0d, want 0 0 0 1 0", dn_valid_a, dn_data_a, occ_a, up_ready_a, stall_a);
    end
    tests_run++;
    if (dn_valid_b !== 1'b0 || dn_data_b !== '0 || occ_b !== 2'd0 || up_ready_b !== 1'b1 || stall_b !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_single: valid=%0b data=%h occ=%0d ready=%0b stall=%0d, want 0 0 0 1 0", dn_valid_b, dn_data_b, occ_b, up_ready_b, stall_b);
    end
    // reset while a payload is held and another is offered, with flush also high
    @(negedge clk); drive_a(1'b1, W'(72'h11), 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; drive_a(1'b1, W'(72'h22), 1'b1, 1'b1);
    @(negedge clk); rst = 1'b0; drive_a(1'b0, '0, 1'b1, 1'b0);
    #2;
    tests_run++;
    if (dn_valid_a !== 1'b0 || dn_data_a !== '0 || occ_a !== 2'd0 || stall_a !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%0b data=%h occ=%0d stall=%0d, want 0 0 0 0", dn_valid_a, dn_data_a, occ_a, stall_a);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        drive_a(1'b1, W'(i + 1), 1'b1, 1'b0);
        drive_b(1'b1, W'(i + 1), 1'b1, 1'b0);
      end else begin
        drive_a(1'b0, '0, 1'b1, 1'b0);
        drive_b(1'b0, '0, 1'b1, 1'b0);
      end
      #2;
      tests_run++;
      if (up_ready_a !== 1'b1 || up_ready_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready[%0d]: skid=%0b single=%0b, want 1 1", i, up_ready_a, up_ready_b);
      end
      if (i > 0) begin
        tests_run++;
        if (dn_valid_a !== 1'b1 || dn_data_a !== W'(i) || occ_a !== 2'd1) begin
          tests_failed++;
          $display("FAIL stream_skid[%0d]: valid=%0b data=%h occ=%0d, want 1 %h 1", i, dn_valid_a, dn_data_a, occ_a, W'(i));
        end
        tests_run++;
        if (dn_valid_b !== 1'b1 || dn_data_b !== W'(i) || occ_b !== 2'd1) begin
          tests_failed++;
          $display("FAIL stream_single[%0d]: valid=%0b data=%h occ=%0d, want 1 %h 1", i, dn_valid_b, dn_data_b, occ_b, W'(i));
        end
      end
    end
    @(negedge clk); #2;
    tests_run++;
    if (dn_valid_a !== 1'b0 || dn_valid_b !== 1'b0 || dn_data_a !== '0 || dn_data_b !== '0) begin
      tests_failed++;
      $display("FAIL stream_drain: valid=%0b/%0b data=%h/%h, want 0/0 0/0", dn_valid_a, dn_valid_b, dn_data_a, dn_data_b);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a_d, b_d, c_d;
    a_d = W'(72'hA0A0); b_d = W'(72'hB0B0); c_d = W'(72'hC0C0);
    apply_reset();
    @(negedge clk); drive_a(1'b1, a_d, 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, b_d, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive_a(1'b1, c_d, 1'b0, 1'b0); #2;
      tests_run++;
      if (occ_a !== 2'd2 || up_ready_a !== 1'b0 || dn_data_a !== a_d) begin
        tests_failed++;
        $display("FAIL bp_full[%0d]: occ=%0d ready=%0b data=%h, want 2 0 %h", k, occ_a, up_ready_a, dn_data_a, a_d);
      end
    end
    @(negedge clk); drive_a(1'b1, c_d, 1'b1, 1'b0); #2;
    tests_run++;
    if (dn_data_a !== a_d || occ_a !== 2'd2) begin
      tests_failed++;
      $display("FAIL bp_first: data=%h occ=%0d, want %h 2", dn_data_a, occ_a, a_d);
    end
    @(negedge clk); #2;
    tests_run++;
    if (dn_data_a !== b_d || occ_a !== 2'd1 || up_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second: data=%h occ=%0d ready=%0b, want %h 1 1", dn_data_a, occ_a, up_ready_a, b_d);
    end
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0); #2;
    tests_run++;
    if (dn_data_a !== c_d || dn_valid_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_third: data=%h valid=%0b, want %h 1", dn_data_a, dn_valid_a, c_d);
    end
    @(negedge clk); #2;
    tests_run++;
    if (dn_valid_a !== 1'b0 || stall_a !== 16'd3) begin
      tests_failed++;
      $display("FAIL bp_stall_count: valid=%0b stall=%0d, want 0 3", dn_valid_a, stall_a);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] d_d;
    d_d = W'(72'hD0D0);
    apply_reset();
    @(negedge clk); drive_a(1'b1, W'(72'h0A), 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, W'(72'h0B), 1'b0, 1'b0);
    @(negedge clk); drive_a(1'b1, d_d, 1'b1, 1'b1); #2;
    tests_run++;
    if (occ_a !== 2'd2 || stall_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_pre: occ=%0d stall=%0d, want 2 1", occ_a, stall_a);
    end
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0); #2;
    tests_run++;
    if (dn_valid_a !== 1'b0 || dn_data_a !== '0 || occ_a !== 2'd0 || up_ready_a !== 1'b1 || stall_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_post: valid=%0b data=%h occ=%0d ready=%0b stall=%0d, want 0 0 0 1 1", dn_valid_a, dn_data_a, occ_a, up_ready_a, stall_a);
    end
    repeat (3) begin
      @(negedge clk); #2;
      tests_run++;
      if (dn_valid_a !== 1'b0 || dn_data_a !== '0) begin
        tests_failed++;
        $display("FAIL flush_no_d: valid=%0b data=%h, want 0 0", dn_valid_a, dn_data_a);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    @(negedge clk); drive_a(1'b1, W'(72'h5A), 1'b0, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk); drive_a(1'b0, '0, 1'b0, 1'b0); #2;
      if (k == 10 || k == 16 || k == 21) begin
        tests_run++;
        if (stall_c !== ((k - 1 >= 15) ? 4'hF : 4'(k - 1)) || stall_a !== 16'(k - 1)) begin
          tests_failed++;
          $display("FAIL saturate[%0d]: stall4=%h stall16=%0d, want %h %0d", k, stall_c, stall_a,
                   (k - 1 >= 15) ? 4'hF : 4'(k - 1), k - 1);
        end
      end
    end
    @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); #2;
    tests_run++;
    if (stall_c !== 4'hF || dn_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL saturate_hold: stall4=%h valid=%0b, want f 0", stall_c, dn_valid_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      drive_a($urandom_range(0, 99) < 70, W'({$urandom(), $urandom(), $urandom()}),
              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      drive_b($urandom_range(0, 99) < 70, W'({$urandom(), $urandom(), $urandom()}),
              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end
    repeat (4) begin
      @(negedge clk); drive_a(1'b0, '0, 1'b1, 1'b0); drive_b(1'b0, '0, 1'b1, 1'b0);
    end
    #2;
    tests_run++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0 || dn_valid_a !== 1'b0 || dn_valid_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_drain: queued=%0d/%0d valid=%0b/%0b, want 0/0 0/0", exp_q_a.size(), exp_q_b.size(), dn_valid_a, dn_valid_b);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
